// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  logic                  grant;
  logic                  busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_dout,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_addr, mem_we, mem_din,
    output grant, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_dout,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_addr, mem_we, mem_din,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-port synchronous RAM.
// One transaction at a time: IDLE (arbitrate) -> ACCESS (MEM_LATENCY+1 cycles) -> RESP (ack).
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          n_reset,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1) + 1;

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_arbiter: MEM_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  last_reg, last_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic                  mem_we_reg, mem_we_next;
  logic [DATA_WIDTH-1:0] mem_din_reg, mem_din_next;
  logic [DATA_WIDTH-1:0] a_rdata_reg, a_rdata_next;
  logic [DATA_WIDTH-1:0] b_rdata_reg, b_rdata_next;
  logic                  pick_b;

  // B wins when it is alone, or when both ask and A was served last.
  assign pick_b = bus.b_req && (!bus.a_req || !last_reg);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      last_reg     <= 1'b1;
      we_reg       <= 1'b0;
      mem_addr_reg <= '0;
      mem_we_reg   <= 1'b0;
      mem_din_reg  <= '0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      last_reg     <= last_next;
      we_reg       <= we_next;
      mem_addr_reg <= mem_addr_next;
      mem_we_reg   <= mem_we_next;
      mem_din_reg  <= mem_din_next;
      a_rdata_reg  <= a_rdata_next;
      b_rdata_reg  <= b_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    last_next     = last_reg;
    we_next       = we_reg;
    mem_addr_next = mem_addr_reg;
    mem_we_next   = 1'b0;
    mem_din_next  = mem_din_reg;
    a_rdata_next  = a_rdata_reg;
    b_rdata_next  = b_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          last_next     = pick_b;
          we_next       = pick_b ? bus.b_we    : bus.a_we;
          mem_we_next   = pick_b ? bus.b_we    : bus.a_we;
          mem_addr_next = pick_b ? bus.b_addr  : bus.a_addr;
          mem_din_next  = pick_b ? bus.b_wdata : bus.a_wdata;
          count_next    = CW'(MEM_LATENCY);
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        // count_reg reaches zero in the cycle where mem_dout is valid.
        if (count_reg == '0) begin
          if (!we_reg) begin
            if (last_reg) b_rdata_next = bus.mem_dout;
            else          a_rdata_next = bus.mem_dout;
          end
          state_next = RESP;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_din  = mem_din_reg;
  assign bus.a_rdata  = a_rdata_reg;
  assign bus.b_rdata  = b_rdata_reg;
  assign bus.a_ack    = (state_reg == RESP) && !last_reg;
  assign bus.b_ack    = (state_reg == RESP) &&  last_reg;
  assign bus.grant    = last_reg;
  assign bus.busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-1 and a latency-3 instance, each
// with its own RAM model, expectation queues and ack/write monitor.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b1 ();
  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b3 ();

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .bus(b1.slave)
  );
  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .n_reset(n_reset), .bus(b3.slave)
  );

  // RAM models: read data appears MEM_LATENCY cycles after the address.
  logic [7:0] ram1 [0:65535];
  logic [7:0] ram3 [0:65535];
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_din;
    b1.mem_dout <= ram1[b1.mem_addr];
    if (b3.mem_we) ram3[b3.mem_addr] <= b3.mem_din;
    p1 <= ram3[b3.mem_addr];
    p2 <= p1;
    b3.mem_dout <= p2;
  end

  typedef struct {logic port; logic [7:0] ra; logic [7:0] rb; int cyc;} rsp_t;
  typedef struct {logic [15:0] addr; logic [7:0] din; int cyc;} wr_t;
  rsp_t q1[$], q3[$];
  wr_t  w1[$], w3[$];
  rsp_t e1, e3;
  wr_t  x1, x3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b1.a_ack || b1.b_ack) begin
      $display("dut1 ack cyc=%0d a_ack=%0b b_ack=%0b a_rdata=%h b_rdata=%h",
               cyc, b1.a_ack, b1.b_ack, b1.a_rdata, b1.b_rdata);
      chk("dut1_ack_onehot", 32'(b1.a_ack & b1.b_ack), 32'd0);
      if (q1.size() == 0) begin
        chk("dut1_unexpected_ack", {30'd0, b1.b_ack, b1.a_ack}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_ack_port", 32'(b1.b_ack), 32'(e1.port));
        chk("dut1_ack_cycle", 32'(cyc), 32'(e1.cyc));
        chk("dut1_a_rdata", 32'(b1.a_rdata), 32'(e1.ra));
        chk("dut1_b_rdata", 32'(b1.b_rdata), 32'(e1.rb));
      end
    end
    if (b1.mem_we) begin
      $display("dut1 write cyc=%0d addr=%h din=%h", cyc, b1.mem_addr, b1.mem_din);
      if (w1.size() == 0) begin
        chk("dut1_unexpected_we", 32'(b1.mem_we), 32'd0);
      end else begin
        x1 = w1.pop_front();
        chk("dut1_we_cycle", 32'(cyc), 32'(x1.cyc));
        chk("dut1_we_addr", 32'(b1.mem_addr), 32'(x1.addr));
        chk("dut1_we_din", 32'(b1.mem_din), 32'(x1.din));
      end
    end
  end

  always @(negedge clk) begin
    if (b3.a_ack || b3.b_ack) begin
      $display("dut3 ack cyc=%0d a_ack=%0b b_ack=%0b a_rdata=%h b_rdata=%h",
               cyc, b3.a_ack, b3.b_ack, b3.a_rdata, b3.b_rdata);
      chk("dut3_ack_onehot", 32'(b3.a_ack & b3.b_ack), 32'd0);
      if (q3.size() == 0) begin
        chk("dut3_unexpected_ack", {30'd0, b3.b_ack, b3.a_ack}, 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_ack_port", 32'(b3.b_ack), 32'(e3.port));
        chk("dut3_ack_cycle", 32'(cyc), 32'(e3.cyc));
        chk("dut3_a_rdata", 32'(b3.a_rdata), 32'(e3.ra));
        chk("dut3_b_rdata", 32'(b3.b_rdata), 32'(e3.rb));
      end
    end
    if (b3.mem_we) begin
      $display("dut3 write cyc=%0d addr=%h din=%h", cyc, b3.mem_addr, b3.mem_din);
      if (w3.size() == 0) begin
        chk("dut3_unexpected_we", 32'(b3.mem_we), 32'd0);
      end else begin
        x3 = w3.pop_front();
        chk("dut3_we_cycle", 32'(cyc), 32'(x3.cyc));
        chk("dut3_we_addr", 32'(b3.mem_addr), 32'(x3.addr));
        chk("dut3_we_din", 32'(b3.mem_din), 32'(x3.din));
      end
    end
  end

  task automatic drive1(input logic port, input logic on, input logic we,
                        input logic [15:0] addr, input logic [7:0] wd);
    if (port) begin
      b1.b_req = on; b1.b_we = we; b1.b_addr = addr; b1.b_wdata = wd;
    end else begin
      b1.a_req = on; b1.a_we = we; b1.a_addr = addr; b1.a_wdata = wd;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_a_ack"},    32'(b1.a_ack),    32'd0);
    chk({tag, "_b_ack"},    32'(b1.b_ack),    32'd0);
    chk({tag, "_mem_we"},   32'(b1.mem_we),   32'd0);
    chk({tag, "_mem_addr"}, 32'(b1.mem_addr), 32'd0);
    chk({tag, "_mem_din"},  32'(b1.mem_din),  32'd0);
    chk({tag, "_a_rdata"},  32'(b1.a_rdata),  32'd0);
    chk({tag, "_b_rdata"},  32'(b1.b_rdata),  32'd0);
    chk({tag, "_grant"},    32'(b1.grant),    32'd1);
    chk({tag, "_busy"},     32'(b1.busy),     32'd0);
  endtask

  int k;

  initial begin
    n_reset = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive1(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    b3.a_req = 1'b0; b3.a_we = 1'b0; b3.a_addr = '0; b3.a_wdata = '0;
    b3.b_req = 1'b0; b3.b_we = 1'b0; b3.b_addr = '0; b3.b_wdata = '0;
    ram3[16'h0100] = 8'hC3;

    // Reset release and idle period
    wait_cycles(3);
    n_reset = 1'b1;
    chk_reset1("rst1");
    chk("rst3_grant", 32'(b3.grant), 32'd1);
    chk("rst3_busy",  32'(b3.busy),  32'd0);
    chk("rst3_a_rdata", 32'(b3.a_rdata), 32'd0);
    wait_cycles(20);

    // A writes 0x2345 <- 0x5A
    k = cyc;
    drive1(1'b0, 1'b1, 1'b1, 16'h2345, 8'h5A);
    w1.push_back('{16'h2345, 8'h5A, k + 1});
    q1.push_back('{1'b0, 8'h00, 8'h00, k + 3});
    wait_cycles(4);
    drive1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("t2_grant", 32'(b1.grant), 32'd0);

    // B reads 0x2345
    k = cyc;
    drive1(1'b1, 1'b1, 1'b0, 16'h2345, 8'h00);
    q1.push_back('{1'b1, 8'h00, 8'h5A, k + 3});
    wait_cycles(4);
    drive1(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_cycles(3);
    chk("t3_b_rdata_held", 32'(b1.b_rdata), 32'h5A);
    chk("t3_a_rdata_kept", 32'(b1.a_rdata), 32'h00);
    chk("t3_grant", 32'(b1.grant), 32'd1);

    // Both request continuously: A reads 0x2345, B writes 0x2345 <- 0x77
    k = cyc;
    drive1(1'b0, 1'b1, 1'b0, 16'h2345, 8'h00);
    drive1(1'b1, 1'b1, 1'b1, 16'h2345, 8'h77);
    for (int n = 0; n < 8; n++) begin
      q1.push_back('{n[0], (n >= 2) ? 8'h77 : 8'h5A, 8'h5A, k + 3 + 4 * n});
      if (n[0]) w1.push_back('{16'h2345, 8'h77, k + 4 * n + 1});
    end
    wait_cycles(32);
    drive1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive1(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_cycles(2);
    chk("t4_busy_after", 32'(b1.busy), 32'd0);

    // Latency-3 instance: A reads 0x0100
    k = cyc;
    b3.a_req = 1'b1; b3.a_we = 1'b0; b3.a_addr = 16'h0100; b3.a_wdata = 8'h00;
    q3.push_back('{1'b0, 8'hC3, 8'h00, k + 5});
    wait_cycles(6);
    b3.a_req = 1'b0;
    wait_cycles(2);

    // Reset in the second ACCESS cycle of a B read
    k = cyc;
    drive1(1'b1, 1'b1, 1'b0, 16'h2345, 8'h00);
    wait_cycles(2);
    chk("t6_busy_before", 32'(b1.busy), 32'd1);
    n_reset = 1'b0;
    #1;
    chk_reset1("t6_async");
    drive1(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_cycles(2);
    n_reset = 1'b1;

    k = cyc;
    drive1(1'b0, 1'b1, 1'b1, 16'h0042, 8'h99);
    w1.push_back('{16'h0042, 8'h99, k + 1});
    q1.push_back('{1'b0, 8'h00, 8'h00, k + 3});
    wait_cycles(4);
    drive1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

    k = cyc;
    drive1(1'b0, 1'b1, 1'b0, 16'h0042, 8'h00);
    q1.push_back('{1'b0, 8'h99, 8'h00, k + 3});
    wait_cycles(4);
    drive1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

    wait_cycles(6);
    chk("end_q1_pending", 32'(q1.size()), 32'd0);
    chk("end_w1_pending", 32'(w1.size()), 32'd0);
    chk("end_q3_pending", 32'(q3.size()), 32'd0);
    chk("end_w3_pending", 32'(w3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
